// File: rtl/crc_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_frame_engine
// Description : Bit-serial CRC engine that either appends a CRC to a message
//               (generate) or verifies a received codeword (check).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_frame_engine #(
    parameter int              MSG_W = 5,
    parameter int              CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = 3'b011,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    input  logic                     in_bit,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MSG_W+CRC_W-1:0]   out_frame,
    output logic                     out_crc_ok,
    output logic                     busy
);

    localparam int FRAME_W = MSG_W + CRC_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_MSG_LAST   = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] c_FRAME_LAST = CNT_W'(FRAME_W - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_mode;
    logic [CRC_W-1:0]   r_crc;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_data;

    logic               w_accept;
    logic               w_last;
    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_shift;
    logic [CRC_W-1:0]   w_crc_next;

    // A start pulse always takes precedence over a bit arriving in the same cycle.
    assign w_accept    = (r_state == c_SHIFT) && in_valid && !start;
    assign w_last      = (r_cnt == (r_mode ? c_FRAME_LAST : c_MSG_LAST));
    assign w_fb        = in_bit ^ r_crc[CRC_W-1];
    assign w_crc_shift = r_crc << 1;
    assign w_crc_next  = w_crc_shift ^ (w_fb ? POLY : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = c_SHIFT;
        end else begin
            case (r_state)
                c_IDLE:  w_state_next = c_IDLE;
                c_SHIFT: if (w_accept && w_last) w_state_next = c_DONE;
                c_DONE:  if (out_ready) w_state_next = c_IDLE;
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == c_SHIFT);
        busy       = (r_state != c_IDLE);
        out_valid  = 1'b0;
        out_frame  = '0;
        out_crc_ok = 1'b0;
        if (r_state == c_DONE) begin
            out_valid  = 1'b1;
            out_frame  = r_mode ? r_data : {r_data[MSG_W-1:0], r_crc};
            out_crc_ok = r_mode && (r_crc == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= 1'b0;
            r_crc  <= INIT;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (start) begin
            r_mode <= mode;
            r_crc  <= INIT;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_crc  <= w_crc_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_data <= {r_data[FRAME_W-2:0], in_bit};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_frame_engine
// Description : Directed and random checks of crc_frame_engine against a
//               polynomial long-division reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_frame_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, mode = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_crc_ok, busy;
    logic [7:0]  out_frame;

    logic        start2 = 1'b0, mode2 = 1'b0, in_valid2 = 1'b0, in_bit2 = 1'b0, out_ready2 = 1'b0;
    logic        in_ready2, out_valid2, out_crc_ok2, busy2;
    logic [15:0] out_frame2;

    int n_checks = 0;
    int n_pass   = 0;

    crc_frame_engine dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
        .out_crc_ok(out_crc_ok), .busy(busy)
    );

    crc_frame_engine #(.MSG_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .in_valid(in_valid2), .in_bit(in_bit2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_frame(out_frame2),
        .out_crc_ok(out_crc_ok2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Remainder of val (nbits wide) divided by the full generator polynomial.
    function automatic logic [31:0] poly_mod(input logic [31:0] val, input int nbits,
                                             input int crcw, input logic [31:0] gen);
        logic [31:0] v = val;
        for (int i = nbits - 1; i >= crcw; i--)
            if (v[i]) v = v ^ (gen << (i - crcw));
        return v & ((32'd1 << crcw) - 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic partial(input bit m, input int n);
        @(negedge clk); start = 1'b1; mode = m; in_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit m, input logic [7:0] bits, input bit gaps,
                             input bit valid_on_start, input int hold, input string tag);
        int          n = m ? 8 : 5;
        int          i = 0;
        int          guard = 0;
        logic [7:0]  exp_frame;
        logic        exp_ok;
        logic [31:0] rem;
        if (m) begin
            exp_frame = bits;
            rem       = poly_mod({24'd0, bits}, 8, 3, 32'hB);
            exp_ok    = (rem == 32'd0);
        end else begin
            rem       = poly_mod({24'd0, bits[4:0], 3'b000}, 8, 3, 32'hB);
            exp_frame = {bits[4:0], rem[2:0]};
            exp_ok    = 1'b0;
        end
        @(negedge clk); start = 1'b1; mode = m; in_valid = valid_on_start; in_bit = 1'b1; out_ready = 1'b0;
        @(negedge clk); start = 1'b0; in_valid = 1'b0; mode = ~m;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        while (i < n && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1; in_bit = bits[n-1-i]; i++;
            end
            @(negedge clk);
            chk({tag, "_out_valid"}, {31'd0, out_valid}, (i == n) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0; mode = 1'b0;
        chk({tag, "_frame"}, {24'd0, out_frame}, {24'd0, exp_frame});
        chk({tag, "_crc_ok"}, {31'd0, out_crc_ok}, {31'd0, exp_ok});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_frame"}, {24'd0, out_frame}, {24'd0, exp_frame});
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_frame_zero"}, {24'd0, out_frame}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run2(input bit m, input logic [15:0] bits, input logic [15:0] exp_frame,
                        input bit exp_ok, input string tag);
        int n = m ? 16 : 8;
        @(negedge clk); start2 = 1'b1; mode2 = m;
        @(negedge clk); start2 = 1'b0;
        chk({tag, "_in_ready"}, {31'd0, in_ready2}, 32'd1);
        for (int i = 0; i < n; i++) begin
            in_valid2 = 1'b1; in_bit2 = bits[n-1-i];
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        chk({tag, "_valid"}, {31'd0, out_valid2}, 32'd1);
        chk({tag, "_frame"}, {16'd0, out_frame2}, {16'd0, exp_frame});
        chk({tag, "_crc_ok"}, {31'd0, out_crc_ok2}, {31'd0, exp_ok});
        out_ready2 = 1'b1;
        @(negedge clk); out_ready2 = 1'b0;
        chk({tag, "_idle"}, {30'd0, busy2, out_valid2}, 32'd0);
    endtask

    initial begin
        logic [7:0]  rb;
        logic [31:0] rem;
        bit          rm;

        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_outs", {22'd0, busy, in_ready, out_crc_ok, out_frame}, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_frame(1'b0, 8'h1A, 1'b0, 1'b0, 0, "gen_d2");
        run_frame(1'b0, 8'h16, 1'b1, 1'b0, 3, "gen_b0");
        run_frame(1'b1, 8'hD2, 1'b0, 1'b0, 1, "chk_d2");
        run_frame(1'b1, 8'hD3, 1'b1, 1'b0, 0, "chk_d3");

        partial(1'b0, 3);
        run_frame(1'b0, 8'h1A, 1'b0, 1'b1, 0, "abort_shift");

        partial(1'b0, 5);
        chk("done_valid", {31'd0, out_valid}, 32'd1);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0; out_ready = 1'b0;
        chk("abort_done_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_done_ready", {31'd0, in_ready}, 32'd1);
        run_frame(1'b1, 8'hB0, 1'b0, 1'b0, 0, "after_abort");

        partial(1'b0, 2);
        #2 reset = 1'b1;
        #1;
        chk("midreset_outs", {20'd0, out_valid, busy, in_ready, out_crc_ok, out_frame}, 32'd0);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'($urandom_range(0, 1)); in_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("post_reset_idle", {30'd0, busy, out_valid}, 32'd0);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 16; t++) begin
            rm = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            if (rm && $urandom_range(0, 1) == 1) begin
                rem = poly_mod({24'd0, rb[4:0], 3'b000}, 8, 3, 32'hB);
                rb  = {rb[4:0], rem[2:0]};
            end
            run_frame(rm, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), "rand");
        end

        run2(1'b0, 16'h0001, 16'h0107, 1'b0, "w8_gen");
        run2(1'b1, 16'h0107, 16'h0107, 1'b1, "w8_chk");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
